// File: rtl/eka_pkg.sv
// Shared definitions for the Eka v1 memory/boot-loader slice.
//   loader_state_t : boot-loader FSM states
//   EKA_MEM_WORDS  : default memory depth in 32-bit words
package eka_pkg;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    RUN  = 2'd2
  } loader_state_t;

  localparam int EKA_MEM_WORDS = 1024;

endpackage

// File: rtl/eka_boot_loader.sv
// Boot loader for eka_mem_v1: receives a little-endian word count N followed
// by N little-endian words over a byte handshake, and emits one memory write
// per completed word. Holds the core in reset until the image is complete.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   ld_byte, ld_valid, ld_ready   : boot byte stream handshake
//   wr_en, wr_idx, wr_word        : array write request (same-edge write)
//   core_reset, load_done         : registered decodes of (state != RUN) / (state == RUN)
module eka_boot_loader
  import eka_pkg::*;
#(
  parameter int MEM_WORDS = EKA_MEM_WORDS,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       ld_byte,
  input  logic             ld_valid,
  output logic             ld_ready,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [31:0]      wr_word,
  output logic             core_reset,
  output logic             load_done
);

  loader_state_t state, state_nxt;
  logic [1:0]    byte_cnt;
  logic [31:0]   word_cnt;
  logic [31:0]   n_words;
  logic [23:0]   asm_bytes;
  logic          accept;
  logic          last_byte;
  logic          in_range;
  logic [31:0]   full_word;

  assign ld_ready  = (state != RUN);
  assign accept    = ld_valid && ld_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  // The byte being accepted lands in bits 31:24; earlier bytes were shifted down.
  assign full_word = {ld_byte, asm_bytes};
  // Words past the end of the array are counted but never written.
  assign in_range  = (word_cnt < 32'(MEM_WORDS));
  assign wr_idx    = word_cnt[IDX_W-1:0];
  assign wr_word   = full_word;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    case (state)
      HDR: begin
        if (last_byte) state_nxt = (full_word == 32'd0) ? RUN : DATA;
      end
      DATA: begin
        if (last_byte) begin
          wr_en = !reset && in_range;
          if (word_cnt == n_words - 32'd1) state_nxt = RUN;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HDR;
      byte_cnt   <= 2'd0;
      word_cnt   <= 32'd0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      core_reset <= (state_nxt != RUN);
      load_done  <= (state_nxt == RUN);
      if (accept) byte_cnt <= byte_cnt + 2'd1;
      if (last_byte && state == HDR)       word_cnt <= 32'd0;
      else if (last_byte && state == DATA) word_cnt <= word_cnt + 32'd1;
    end
  end

  // Byte assembly and the captured count are pure data; byte_cnt qualifies them.
  always_ff @(posedge clk) begin
    if (accept) asm_bytes <= {ld_byte, asm_bytes[23:8]};
    if (last_byte && state == HDR) n_words <= full_word;
  end

endmodule

// File: rtl/eka_mem_v1.sv
// Unified instruction/data memory for the Eka v1 single-cycle core with an
// integrated boot loader.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   inst_addr, instruction  : combinational fetch port
//   data_addr, mem_wr_data,
//   mem_wr, mem_rd,
//   mem_rd_data             : combinational load / posedge store port
//   ld_byte, ld_valid,
//   ld_ready                : boot byte stream
//   core_reset, load_done   : core reset hold / loader finished
module eka_mem_v1
  import eka_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = EKA_MEM_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [31:0]           instruction,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           mem_wr_data,
  input  logic                  mem_wr,
  input  logic                  mem_rd,
  output logic [31:0]           mem_rd_data,
  input  logic [7:0]            ld_byte,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  output logic                  core_reset,
  output logic                  load_done
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [31:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] inst_idx;
  logic [IDX_W-1:0] data_idx;
  logic             ld_wr_en;
  logic [IDX_W-1:0] ld_wr_idx;
  logic [31:0]      ld_wr_word;
  logic             core_store;
  logic             unused_addr_bits;

  // Byte offset and upper address bits are dropped: addresses wrap.
  assign inst_idx = inst_addr[IDX_W+1:2];
  assign data_idx = data_addr[IDX_W+1:2];
  assign unused_addr_bits = ^{inst_addr, data_addr};

  eka_boot_loader #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_loader (
    .clk        (clk),
    .reset      (reset),
    .ld_byte    (ld_byte),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .wr_en      (ld_wr_en),
    .wr_idx     (ld_wr_idx),
    .wr_word    (ld_wr_word),
    .core_reset (core_reset),
    .load_done  (load_done)
  );

  assign instruction = mem[inst_idx];
  assign mem_rd_data = mem_rd ? mem[data_idx] : 32'd0;

  // load_done is exactly (state == RUN), so loader and core writes never overlap.
  assign core_store = mem_wr && load_done && !reset;

  always_ff @(posedge clk) begin
    if (ld_wr_en)        mem[ld_wr_idx] <= ld_wr_word;
    else if (core_store) mem[data_idx]  <= mem_wr_data;
  end

endmodule
